// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters, the arbiter and the FIFO write side.
// The arbiter takes the master modport; the requester/FIFO environment takes slave.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [ID_W-1:0]               grant_id;
    logic [CNT_WIDTH-1:0]          write_cnt;
    logic [CNT_WIDTH-1:0]          stall_cnt;

    modport master (
        input  req, req_data, full,
        output req_ack, wr_en, data_in, grant_id, write_cnt, stall_cnt
    );

    modport slave (
        output req, req_data, full,
        input  req_ack, wr_en, data_in, grant_id, write_cnt, stall_cnt
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: round-robin between NUM_REQ requesters
// with a bounded burst lock, zero-latency grant path, and saturating write/stall
// counters. Everything lives in the write clock domain.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    fifo_wr_arbiter_if.master   bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);

    logic [ID_W-1:0]      r_rr_ptr;
    logic [ID_W-1:0]      r_owner;
    logic                 r_lock;
    logic [BC_W-1:0]      r_burst_cnt;
    logic [CNT_WIDTH-1:0] r_write_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    logic                 w_any;
    logic                 w_owner_req;
    logic [ID_W-1:0]      w_search;
    logic [ID_W-1:0]      w_sel;
    logic                 w_xfer;
    logic [BC_W-1:0]      w_n;
    logic [ID_W-1:0]      w_rr_ptr_nxt;
    logic [ID_W-1:0]      w_owner_nxt;
    logic                 w_lock_nxt;
    logic [BC_W-1:0]      w_burst_cnt_nxt;

    // Requester selection: locked owner wins while it still requests, else rotate from rr_ptr.
    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        w_search    = r_rr_ptr;
        w_any       = |bus.req;
        w_owner_req = bus.req[r_owner];
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found && bus.req[idx]) begin
                found    = 1'b1;
                w_search = ID_W'(idx);
            end else begin
                found    = found;
            end
        end
        if (r_lock && w_owner_req) begin
            w_sel = r_owner;
        end else begin
            w_sel = w_search;
        end
        // full gates the write in the same cycle, so wr_en && full can never occur.
        w_xfer = w_any && !bus.full && !wr_rst;
    end

    // FIFO-facing outputs and per-requester acknowledge, all zero-latency.
    always_comb begin
        bus.wr_en    = w_xfer;
        bus.req_ack  = '0;
        bus.data_in  = '0;
        bus.grant_id = '0;
        if (w_xfer) begin
            bus.req_ack = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
        end else begin
            bus.req_ack = '0;
        end
        if (w_any) begin
            bus.data_in  = bus.req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
            bus.grant_id = w_sel;
        end else begin
            bus.data_in  = '0;
            bus.grant_id = '0;
        end
        bus.write_cnt = r_write_cnt;
        bus.stall_cnt = r_stall_cnt;
    end

    // Next arbitration state: advance burst/rotation on a write, drop an abandoned lock, else hold.
    always_comb begin
        w_rr_ptr_nxt    = r_rr_ptr;
        w_owner_nxt     = r_owner;
        w_lock_nxt      = r_lock;
        w_burst_cnt_nxt = r_burst_cnt;
        if (r_lock && (w_sel == r_owner)) begin
            w_n = r_burst_cnt + BC_W'(1);
        end else begin
            w_n = BC_W'(1);
        end
        if (w_xfer) begin
            if (w_sel == ID_W'(NUM_REQ - 1)) begin
                w_rr_ptr_nxt = '0;
            end else begin
                w_rr_ptr_nxt = w_sel + ID_W'(1);
            end
            if (w_n == BC_W'(MAX_BURST)) begin
                w_lock_nxt      = 1'b0;
                w_burst_cnt_nxt = '0;
            end else begin
                w_lock_nxt      = 1'b1;
                w_owner_nxt     = w_sel;
                w_burst_cnt_nxt = w_n;
            end
        end else if (r_lock && !w_owner_req) begin
            // rr_ptr already points past the owner, so the search simply resumes there.
            w_lock_nxt      = 1'b0;
            w_burst_cnt_nxt = '0;
        end else begin
            // Stalled by full (or idle): a still-requesting owner keeps its lock and count.
            w_lock_nxt      = r_lock;
        end
    end

    // Arbitration state register with synchronous reset.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_lock      <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_lock      <= w_lock_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    // Saturating performance counters: accepted writes and full-blocked request cycles.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_write_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer && (r_write_cnt != {CNT_WIDTH{1'b1}})) begin
                r_write_cnt <= r_write_cnt + CNT_WIDTH'(1);
            end else begin
                r_write_cnt <= r_write_cnt;
            end
            if (w_any && bus.full && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (MAX_BURST=4/CNT_WIDTH=16 and
// MAX_BURST=1/CNT_WIDTH=4) share one stimulus stream and are compared every
// cycle against a queue-free behavioural model (owner + words-remaining view),
// plus literal expectations for the directed scenarios.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        t_rst;
    logic [3:0]  t_req;
    logic        t_full;
    logic [31:0] t_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) if1 ();
    fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .CNT_WIDTH(4))  if2 ();

    assign if1.req = t_req;  assign if1.req_data = t_data;  assign if1.full = t_full;
    assign if2.req = t_req;  assign if2.req_data = t_data;  assign if2.full = t_full;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4), .CNT_WIDTH(16)) dut1 (
        .wr_clk(clk), .wr_rst(t_rst), .bus(if1.master));
    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1), .CNT_WIDTH(4)) dut2 (
        .wr_clk(clk), .wr_rst(t_rst), .bus(if2.master));

    typedef struct {
        int     ptr;    // where the rotating search starts
        int     owner;  // burst owner, -1 when nobody holds a burst
        int     rem;    // words still allowed in the owner's burst
        longint wc;     // unbounded write count
        longint sc;     // unbounded stall count
    } mstate_t;

    mstate_t m1, m2;
    bit      m_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One cycle of the behavioural arbiter: who is picked, is it written, what state follows.
    task automatic model_step(input mstate_t s, input int maxb, input logic [3:0] rq,
                              input bit fl, input bit rs,
                              output int sel, output bit any, output bit xfer,
                              output mstate_t ns);
        bit found;
        any   = (rq != 4'b0000);
        sel   = 0;
        found = 1'b0;
        if (s.owner >= 0 && rq[s.owner]) begin
            sel = s.owner;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && rq[(s.ptr + k) % N]) begin
                    found = 1'b1;
                    sel   = (s.ptr + k) % N;
                end
            end
        end
        xfer = any && !fl && !rs;
        ns   = s;
        if (rs) begin
            ns = '{0, -1, 0, 0, 0};
        end else begin
            if (xfer) begin
                ns.wc  = s.wc + 1;
                ns.ptr = (sel + 1) % N;
                ns.rem = (s.owner == sel) ? s.rem - 1 : maxb - 1;
                ns.owner = (ns.rem == 0) ? -1 : sel;
            end else if (s.owner >= 0 && !rq[s.owner]) begin
                ns.owner = -1;
            end
            if (any && fl) ns.sc = s.sc + 1;
        end
    endtask

    // Per-cycle comparison of both DUTs against the model, then advance the model.
    always @(negedge clk) begin
        int sel1, sel2; bit any1, any2, x1, x2; mstate_t n1, n2;
        model_step(m1, 4, t_req, t_full, t_rst, sel1, any1, x1, n1);
        model_step(m2, 1, t_req, t_full, t_rst, sel2, any2, x2, n2);
        if (t_rst) begin
            chk("rst_wr_en1", if1.wr_en, 0);   chk("rst_ack1", if1.req_ack, 0);
            chk("rst_wr_en2", if2.wr_en, 0);   chk("rst_ack2", if2.req_ack, 0);
        end
        if (m_valid) begin
            chk("wr_en1", if1.wr_en, x1);
            chk("ack1", if1.req_ack, x1 ? (4'b0001 << sel1) : 4'b0000);
            chk("data1", if1.data_in, any1 ? t_data[sel1*DW +: DW] : 8'h00);
            chk("gid1", if1.grant_id, any1 ? sel1 : 0);
            chk("wcnt1", if1.write_cnt, sat(m1.wc, 16));
            chk("scnt1", if1.stall_cnt, sat(m1.sc, 16));
            chk("wr_en2", if2.wr_en, x2);
            chk("ack2", if2.req_ack, x2 ? (4'b0001 << sel2) : 4'b0000);
            chk("data2", if2.data_in, any2 ? t_data[sel2*DW +: DW] : 8'h00);
            chk("gid2", if2.grant_id, any2 ? sel2 : 0);
            chk("wcnt2", if2.write_cnt, sat(m2.wc, 4));
            chk("scnt2", if2.stall_cnt, sat(m2.sc, 4));
            chk("no_wr_when_full", if1.wr_en & t_full, 0);
        end
        m1 = n1;
        m2 = n2;
        if (t_rst) m_valid = 1'b1;
    end

    task automatic step(input bit rs, input logic [3:0] rq, input bit fl, input logic [31:0] dat);
        @(posedge clk);
        #1;
        t_rst  = rs;
        t_req  = rq;
        t_full = fl;
        t_data = dat;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  lit_data [4];
        logic [3:0]  seq_early [5];
        logic [3:0]  rq;
        logic [31:0] dat;
        lit_data  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        seq_early = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        t_rst  = 1'b1;
        t_req  = 4'b1111;
        t_full = 1'b0;
        t_data = 32'hD4C3B2A1;

        // Reset held with everyone requesting: no writes.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'b1111, 1'b0, 32'hD4C3B2A1);
            chk("reset_wr_en", if1.wr_en, 0);
        end

        // Burst-of-4 rotation with all four requesting.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'b1111, 1'b0, 32'hD4C3B2A1);
            if (i == 0) begin
                chk("post_reset_wcnt", if1.write_cnt, 0);
                chk("post_reset_scnt", if1.stall_cnt, 0);
            end
            chk("rot_ack", if1.req_ack, 4'b0001 << (i / 4));
            chk("rot_data", if1.data_in, lit_data[i / 4]);
        end

        // Early release: requester 1 alone for two words, then 0 and 2 compete.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b0010, 1'b0, 32'hD4C3B2A1);
            if (i == 0) chk("rot_wcnt16", if1.write_cnt, 16);
            chk("early_ack1", if1.req_ack, 4'b0010);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0101, 1'b0, 32'hD4C3B2A1);
            chk("early_seq", if1.req_ack, seq_early[i]);
        end

        // Full stall in the middle of requester 3's burst.
        step(1'b1, 4'b0000, 1'b0, 32'hD4C3B2A1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 4'b1000, 1'b0, 32'hD4C3B2A1);
            chk("stall_pre_ack", if1.req_ack, 4'b1000);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1000, 1'b1, 32'hD4C3B2A1);
            chk("stall_wr_en", if1.wr_en, 0);
        end
        step(1'b0, 4'b1001, 1'b0, 32'hD4C3B2A1);
        chk("stall_cnt5", if1.stall_cnt, 5);
        chk("stall_wcnt2", if1.write_cnt, 2);
        chk("resume_ack_a", if1.req_ack, 4'b1000);
        step(1'b0, 4'b1001, 1'b0, 32'hD4C3B2A1);
        chk("resume_ack_b", if1.req_ack, 4'b1000);
        step(1'b0, 4'b1001, 1'b0, 32'hD4C3B2A1);
        chk("resume_rotate", if1.req_ack, 4'b0001);

        // MAX_BURST=1 alternation and 4-bit counter saturation.
        step(1'b1, 4'b1010, 1'b0, 32'hD4C3B2A1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'b1010, 1'b0, 32'hD4C3B2A1);
            chk("mb1_alt", if2.req_ack, (i % 2 == 0) ? 4'b0010 : 4'b1000);
        end
        step(1'b0, 4'b0000, 1'b0, 32'hD4C3B2A1);
        chk("sat_wcnt15", if2.write_cnt, 15);
        chk("wcnt20", if1.write_cnt, 20);

        // Random requests, data, full toggling and occasional reset.
        rq  = 4'b0000;
        dat = 32'hD4C3B2A1;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rq[i] = ~rq[i];
                    if (rq[i]) dat[i*DW +: DW] = 8'($urandom);
                end
            end
            step(($urandom_range(0, 99) == 0), rq, ($urandom_range(0, 2) == 0), dat);
        end

        step(1'b0, 4'b0000, 1'b0, dat);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO, living entirely in the write clock domain. It shares the single FIFO write port (wr_en/data_in/full) between NUM_REQ requesters. Arbitration is round-robin, with a bounded burst lock so a requester can stream up to MAX_BURST consecutive words. It never issues a write while the FIFO reports full, and exposes saturating write and stall counters for performance monitoring.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 8, FIFO word width
- MAX_BURST, 4, max consecutive accepted writes per grant (≥1; 1 = pure round-robin)
- CNT_WIDTH, 16, width of status counters

Ports:
- wr_clk  in  1  write-domain clock; one clock, all state on its rising edge
- wr_rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request; held with its data until acked
- req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ack  out  NUM_REQ  one-hot; bit i high = requester i's word written this cycle
- full  in  1  FIFO full flag (write domain)
- wr_en  out  1  FIFO write enable
- data_in  out  DATA_WIDTH  FIFO write data
- grant_id  out  clog2(NUM_REQ)  index of requester selected this cycle (valid when any req high)
- write_cnt  out  CNT_WIDTH  accepted writes, saturating
- stall_cnt  out  CNT_WIDTH  cycles with any req high and full high, saturating

## Operation
- State: rr_ptr (next-priority index), lock (1b), owner (index), burst_cnt (clog2(MAX_BURST+1) bits), write_cnt, stall_cnt.
- Selection (combinational): if lock && req[owner], sel = owner; else sel = first i with req[i] set, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
- Transfer = |req && !full && !wr_rst. On transfer: wr_en=1, data_in=req_data[sel], req_ack=onehot(sel). Otherwise wr_en=0 and req_ack=0.
- data_in = req_data[sel] whenever any req is high, and 0 otherwise. grant_id = sel, or 0 when no req is high.
- Update on transfer:
  - rr_ptr ← (sel+1) mod NUM_REQ.
  - n = (lock && sel==owner) ? burst_cnt+1 : 1.
  - If n == MAX_BURST: lock←0, burst_cnt←0. Else: lock←1, owner←sel, burst_cnt←n.
- No transfer with lock && !req[owner]: lock←0, burst_cnt←0; rr_ptr unchanged (already owner+1).
- No transfer because full: all arbitration state holds. A stalled locked owner keeps the lock.
- Counters:
  - write_cnt +1 per transfer.
  - stall_cnt +1 per cycle with |req && full.
  - Both saturate at all-ones.
- Requester contract: req[i] and its data stay stable until req_ack[i]. Dropping req before ack is legal and simply withdraws the request.

## Timing
- Reset (wr_rst high at edge): rr_ptr=0, lock=0, owner=0, burst_cnt=0, write_cnt=0, stall_cnt=0.
- While wr_rst is high, wr_en=0 and req_ack=0 combinationally, regardless of req/full.
- Reset mid-burst drops the lock. The first cycle after reset arbitrates from index 0.
- Zero-latency path: req → wr_en/req_ack/data_in in the same cycle. full gates wr_en combinationally, so wr_en && full never occurs. This is required because the FIFO updates full at the edge following each write.
- Max throughput is one word per cycle. Back-to-back writes from one requester continue while its req stays high, up to MAX_BURST. Writes then rotate to the next requesting index.
- Starvation bound: a continuously requesting source is acked within (NUM_REQ−1)*MAX_BURST accepted writes.
- Single requester: after its burst ends, rr_ptr moves past it, but the search wraps back. It gets its next word the following cycle with no bubble and starts a new burst.
- full rising mid-burst: no ack and no state change until full drops; the owner then resumes with its remaining burst count.

## Test plan
- Reset/idle: hold wr_rst 3 cycles with req=4'b1111 and full=0 → wr_en=0, req_ack=0 throughout. After release, first ack goes to requester 0 and the counters read 0.
- Burst and rotation, MAX_BURST=4, NUM_REQ=4, req=4'b1111 constant, full=0 for 16 cycles → req_ack sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3. data_in matches each owner's word, write_cnt=16.
- Early release: req[1] only for 2 cycles, then req=4'b0101 → two acks to 1, then ack to 2 (search starts at rr_ptr=2). Requester 0 is served after requester 2's burst.
- Full stall: requester 3 locked with burst_cnt=2, then assert full for 5 cycles → wr_en=0 for all 5 and stall_cnt increases by 5. On release, requester 3 gets exactly 2 more acks, then the grant rotates.
- MAX_BURST=1 with req=4'b1010 → acks alternate 1,3,1,3; wr_en is never high while full is high (run random full toggling for 1000 cycles).
- Saturation: CNT_WIDTH=4, 20 consecutive transfers → write_cnt holds at 15.
